jtag_tap: RTL and testbench

JTAG_TAP -- requirements
Module: jtag_tap

---
 rtl/jtag_tap_pkg.sv | 32 +++
 rtl/jtag_tap_fsm.sv | 58 +++++
 rtl/jtag_tap.sv | 127 ++++++++++++
 tb/tb_jtag_tap.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: controller state codes and instruction opcodes.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_e;

  // Opcodes are sized to IR_WIDTH at the point of use; -1 widens to all-ones.
  localparam int OPC_BYPASS = -1;
  localparam int OPC_IDCODE = 1;
  localparam int OPC_USER   = 2;

  function automatic logic is_shift(tap_state_e s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, advanced on each TCK rising edge.
//
// state  | meaning
// TLR    | test-logic-reset, instruction forced to reset value
// RTI    | run-test/idle
// SEL_DR | select data-register scan
// CAP_DR | parallel load of selected data register
// SH_DR  | data register shifts TDI->TDO
// EX1_DR | exit 1 of data scan
// PAU_DR | data scan paused
// EX2_DR | exit 2 of data scan
// UPD_DR | data register update
// SEL_IR | select instruction scan
// CAP_IR | instruction shifter loads ...01
// SH_IR  | instruction shifter shifts TDI->TDO
// EX1_IR | exit 1 of instruction scan
// PAU_IR | instruction scan paused
// EX2_IR | exit 2 of instruction scan
// UPD_IR | instruction register update
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e state_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:    state_q <= TMS ? TLR    : RTI;
        RTI:    state_q <= TMS ? SEL_DR : RTI;
        SEL_DR: state_q <= TMS ? SEL_IR : CAP_DR;
        CAP_DR: state_q <= TMS ? EX1_DR : SH_DR;
        SH_DR:  state_q <= TMS ? EX1_DR : SH_DR;
        EX1_DR: state_q <= TMS ? UPD_DR : PAU_DR;
        PAU_DR: state_q <= TMS ? EX2_DR : PAU_DR;
        EX2_DR: state_q <= TMS ? UPD_DR : SH_DR;
        UPD_DR: state_q <= TMS ? SEL_DR : RTI;
        SEL_IR: state_q <= TMS ? TLR    : CAP_IR;
        CAP_IR: state_q <= TMS ? EX1_IR : SH_IR;
        SH_IR:  state_q <= TMS ? EX1_IR : SH_IR;
        EX1_IR: state_q <= TMS ? UPD_IR : PAU_IR;
        PAU_IR: state_q <= TMS ? EX2_IR : PAU_IR;
        EX2_IR: state_q <= TMS ? UPD_IR : SH_IR;
        UPD_IR: state_q <= TMS ? SEL_DR : RTI;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP with BYPASS, USER data register and optional IDCODE register.
// Macro JTAG_TAP_IDCODE_EN enables IDCODE and makes it the reset instruction.
module jtag_tap
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned DR_WIDTH   = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                tdo_en,
  output logic [3:0]          state_obs,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic [DR_WIDTH-1:0] user_dr_out,
  output logic                user_update
);

  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(OPC_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OPC_BYPASS);
`endif

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [31:0]         id_sh_q, id_sh_d;
  logic [DR_WIDTH-1:0] user_sh_q, user_sh_d;
  logic [DR_WIDTH-1:0] user_dr_out_q, user_dr_out_d;
  logic                byp_q, byp_d;
  logic                user_update_q, user_update_d;
  logic                sel_user, sel_idcode;

  jtag_tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (state)
  );

  assign ir_out   = (state == TLR) ? IR_RESET : ir_q;
  assign sel_user = (ir_out == IR_USER);
`ifdef JTAG_TAP_IDCODE_EN
  assign sel_idcode = (ir_out == IR_IDCODE);
`else
  assign sel_idcode = 1'b0;
`endif

  // Anything not USER or IDCODE routes through the 1-bit bypass stage.
  always_comb begin
    ir_sh_d       = ir_sh_q;
    ir_d          = ir_q;
    id_sh_d       = id_sh_q;
    user_sh_d     = user_sh_q;
    byp_d         = byp_q;
    user_dr_out_d = user_dr_out_q;
    user_update_d = 1'b0;
    case (state)
      TLR:    ir_d    = IR_RESET;
      CAP_IR: ir_sh_d = IR_CAPTURE;
      SH_IR:  ir_sh_d = {TDI, ir_sh_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d    = ir_sh_q;
      CAP_DR: begin
        if (sel_user)        user_sh_d = user_dr_in;
        else if (sel_idcode) id_sh_d   = IDCODE_VAL;
        else                 byp_d     = 1'b0;
      end
      SH_DR: begin
        if (sel_user)        user_sh_d = DR_WIDTH'({TDI, user_sh_q} >> 1);
        else if (sel_idcode) id_sh_d   = {TDI, id_sh_q[31:1]};
        else                 byp_d     = TDI;
      end
      UPD_DR: begin
        if (sel_user) begin
          user_dr_out_d = user_sh_q;
          user_update_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sh_q       <= '0;
      ir_q          <= IR_RESET;
      id_sh_q       <= '0;
      user_sh_q     <= '0;
      byp_q         <= 1'b0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
    end else begin
      ir_sh_q       <= ir_sh_d;
      ir_q          <= ir_d;
      id_sh_q       <= id_sh_d;
      user_sh_q     <= user_sh_d;
      byp_q         <= byp_d;
      user_dr_out_q <= user_dr_out_d;
      user_update_q <= user_update_d;
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (state == SH_IR) begin
      TDO = ir_sh_q[0];
    end else if (state == SH_DR) begin
      if (sel_user)        TDO = user_sh_q[0];
      else if (sel_idcode) TDO = id_sh_q[0];
      else                 TDO = byp_q;
    end
  end

  assign tdo_en      = is_shift(state);
  assign state_obs   = state;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: directed scans plus a random TMS/TDI walk
// compared against a queue-based model of the TAP.
module tb_jtag_tap;

  localparam int          IRW = 4;
  localparam int          DRW = 8;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [3:0] RESET_IR = ID_EN ? 4'b0001 : 4'b1111;

  logic           TCK = 1'b0;
  logic           TRST = 1'b1;
  logic           TMS = 1'b1;
  logic           TDI = 1'b0;
  logic           TDO, tdo_en, user_update;
  logic [3:0]     state_obs;
  logic [IRW-1:0] ir_out;
  logic [DRW-1:0] user_dr_in = '0;
  logic [DRW-1:0] user_dr_out;

  int checks = 0;
  int errors = 0;

  always #5 TCK = ~TCK;

  jtag_tap #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .state_obs(state_obs), .ir_out(ir_out), .user_dr_in(user_dr_in),
    .user_dr_out(user_dr_out), .user_update(user_update)
  );

  // Standard 1149.1 transitions indexed by state code.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int             m_state;
  bit             m_ir_sh[$];
  bit             m_dr[$];
  logic [IRW-1:0] m_ir_act;
  logic [DRW-1:0] m_uout;
  bit             m_upd;

  function automatic logic [IRW-1:0] m_ir_out();
    return (m_state == 0) ? RESET_IR : m_ir_act;
  endfunction

  function automatic bit m_tdo();
    if (m_state == 11 && m_ir_sh.size() > 0) return m_ir_sh[0];
    if (m_state == 4 && m_dr.size() > 0) return m_dr[0];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ir_sh.delete();
    for (int i = 0; i < IRW; i++) m_ir_sh.push_back(1'b0);
    m_dr.delete();
    m_ir_act = RESET_IR;
    m_uout = '0;
    m_upd = 1'b0;
  endtask

  task automatic model_edge(input bit tms, input bit tdi);
    logic [IRW-1:0] op;
    bit             b;
    op = m_ir_out();
    m_upd = 1'b0;
    case (m_state)
      0:  m_ir_act = RESET_IR;
      10: begin
        m_ir_sh.delete();
        m_ir_sh.push_back(1'b1);
        for (int i = 1; i < IRW; i++) m_ir_sh.push_back(1'b0);
      end
      11: begin b = m_ir_sh.pop_front(); m_ir_sh.push_back(tdi); end
      15: for (int i = 0; i < IRW; i++) m_ir_act[i] = m_ir_sh[i];
      3: begin
        m_dr.delete();
        if (op == 4'd2) for (int i = 0; i < DRW; i++) m_dr.push_back(user_dr_in[i]);
        else if (ID_EN && op == 4'd1) for (int i = 0; i < 32; i++) m_dr.push_back(IDV[i]);
        else m_dr.push_back(1'b0);
      end
      4: begin b = m_dr.pop_front(); m_dr.push_back(tdi); end
      8: if (op == 4'd2) begin
        for (int i = 0; i < DRW; i++) m_uout[i] = m_dr[i];
        m_upd = 1'b1;
      end
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
  endtask

  // One TCK cycle: drive, sample TDO before the edge, advance model, settle.
  task automatic step(input bit tms, input bit tdi, output bit tdo_pre);
    TMS = tms;
    TDI = tdi;
    tdo_pre = TDO;
    @(posedge TCK);
    model_edge(tms, tdi);
    @(negedge TCK);
  endtask

  task automatic do_reset();
    @(negedge TCK);
    TRST = 1'b0;
    #2;
    model_reset();
    TRST = 1'b1;
  endtask

  task automatic goto_rti();
    bit b;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  task automatic shift_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] tdo_bits);
    bit b;
    step(1'b1, 1'b0, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < IRW; i++) begin
      step(i == IRW - 1, val[i], b);
      tdo_bits[i] = b;
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    bit b;
    dout = '0;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b);
      dout[i] = b;
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  task automatic test_reset();
    bit b;
    #1 TRST = 1'b0;
    model_reset();
    repeat (3) @(negedge TCK);
    checks++; if (state_obs !== 4'h0) begin errors++; $display("FAIL reset_state got %h want 0", state_obs); end
    checks++; if (ir_out !== RESET_IR) begin errors++; $display("FAIL reset_ir got %h want %h", ir_out, RESET_IR); end
    checks++; if (TDO !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b/%b want 0/0", TDO, tdo_en); end
    checks++; if (user_dr_out !== '0 || user_update !== 1'b0) begin errors++; $display("FAIL reset_user got %h/%b want 0/0", user_dr_out, user_update); end
    #2 TRST = 1'b1;
    step(1'b0, 1'b0, b);
    checks++; if (state_obs !== 4'h1) begin errors++; $display("FAIL first_edge got %h want 1", state_obs); end
  endtask

  task automatic test_idcode();
    logic [31:0] dout;
    bit          b;
    do_reset();
    step(1'b0, 1'b0, b);
    shift_dr(32'h0, 32, dout);
    checks++; if (dout !== (ID_EN ? IDV : 32'h0)) begin errors++; $display("FAIL idcode_read got %h want %h", dout, ID_EN ? IDV : 32'h0); end
    checks++; if (user_update !== 1'b0) begin errors++; $display("FAIL idcode_no_update got %b want 0", user_update); end
  endtask

  task automatic test_user();
    logic [IRW-1:0] ib;
    logic [31:0]    dout;
    bit             b;
    user_dr_in = 8'h3C;
    shift_ir(4'b0010, ib);
    checks++; if (ir_out !== 4'b0010) begin errors++; $display("FAIL user_ir got %h want 2", ir_out); end
    shift_dr(32'hA5, DRW, dout);
    checks++; if (dout[7:0] !== 8'h3C) begin errors++; $display("FAIL user_capture got %h want 3c", dout[7:0]); end
    checks++; if (user_dr_out !== 8'hA5) begin errors++; $display("FAIL user_out got %h want a5", user_dr_out); end
    checks++; if (user_update !== 1'b1) begin errors++; $display("FAIL user_pulse_hi got %b want 1", user_update); end
    step(1'b0, 1'b0, b);
    checks++; if (user_update !== 1'b0) begin errors++; $display("FAIL user_pulse_lo got %b want 0", user_update); end
  endtask

  task automatic test_bypass();
    logic [IRW-1:0] ib;
    logic [IRW-1:0] opc [2] = '{4'b1111, 4'b0101};
    logic [31:0]    dout;
    for (int k = 0; k < 2; k++) begin
      shift_ir(opc[k], ib);
      shift_dr(32'b1101, 4, dout);
      checks++; if (dout[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_%0d got %b want 1010", k, dout[3:0]); end
      checks++; if (user_update !== 1'b0 || user_dr_out !== 8'hA5) begin errors++; $display("FAIL bypass_noupd_%0d got %b/%h want 0/a5", k, user_update, user_dr_out); end
    end
  endtask

  task automatic test_capture_ir();
    logic [IRW-1:0] ib;
    shift_ir(4'b1111, ib);
    checks++; if (ib !== 4'b0001) begin errors++; $display("FAIL capture_ir got %b want 0001", ib); end
    checks++; if (ir_out !== 4'b1111) begin errors++; $display("FAIL capture_ir_upd got %h want f", ir_out); end
  endtask

  task automatic test_forced_reset();
    logic [IRW-1:0] ib;
    bit             b;
    shift_ir(4'b0010, ib);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    checks++; if (state_obs !== 4'h6) begin errors++; $display("FAIL pause_dr got %h want 6", state_obs); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
    checks++; if (state_obs !== 4'h0) begin errors++; $display("FAIL tms5_state got %h want 0", state_obs); end
    checks++; if (ir_out !== RESET_IR) begin errors++; $display("FAIL tms5_ir got %h want %h", ir_out, RESET_IR); end
  endtask

  task automatic test_async_reset();
    logic [IRW-1:0] ib;
    bit             b;
    do_reset();
    step(1'b0, 1'b0, b);
    user_dr_in = 8'($urandom);
    shift_ir(4'b0010, ib);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), b);
    checks++; if (tdo_en !== 1'b1) begin errors++; $display("FAIL mid_shift_en got %b want 1", tdo_en); end
    #1 TRST = 1'b0;
    #1;
    model_reset();
    checks++; if (state_obs !== 4'h0 || tdo_en !== 1'b0 || TDO !== 1'b0) begin errors++; $display("FAIL async_state got %h/%b/%b want 0/0/0", state_obs, tdo_en, TDO); end
    checks++; if (user_dr_out !== 8'h00 || ir_out !== RESET_IR) begin errors++; $display("FAIL async_regs got %h/%h want 00/%h", user_dr_out, ir_out, RESET_IR); end
    @(negedge TCK);
    checks++; if (state_obs !== 4'h0) begin errors++; $display("FAIL async_hold got %h want 0", state_obs); end
    TRST = 1'b1;
    step(1'b0, 1'b0, b);
    checks++; if (state_obs !== 4'h1) begin errors++; $display("FAIL async_release got %h want 1", state_obs); end
  endtask

  task automatic test_random();
    logic [IRW-1:0] opc [5] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd15};
    logic [IRW-1:0] ib;
    bit             tms, tdi, got, exp_tdo;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        goto_rti();
        shift_ir(opc[$urandom_range(0, 4)], ib);
      end
      tms = ($urandom_range(0, 9) < 4);
      tdi = 1'($urandom);
      user_dr_in = 8'($urandom);
      exp_tdo = m_tdo();
      step(tms, tdi, got);
      checks++; if (got !== exp_tdo) begin errors++; $display("FAIL rnd_tdo n=%0d got %b want %b", n, got, exp_tdo); end
      checks++; if (state_obs !== 4'(m_state)) begin errors++; $display("FAIL rnd_state n=%0d got %h want %h", n, state_obs, 4'(m_state)); end
      checks++; if (tdo_en !== (m_state == 4 || m_state == 11)) begin errors++; $display("FAIL rnd_tdo_en n=%0d got %b", n, tdo_en); end
      checks++; if (ir_out !== m_ir_out()) begin errors++; $display("FAIL rnd_ir n=%0d got %h want %h", n, ir_out, m_ir_out()); end
      checks++; if (user_dr_out !== m_uout) begin errors++; $display("FAIL rnd_uout n=%0d got %h want %h", n, user_dr_out, m_uout); end
      checks++; if (user_update !== m_upd) begin errors++; $display("FAIL rnd_upd n=%0d got %b want %b", n, user_update, m_upd); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idcode();
    test_user();
    test_bypass();
    test_capture_ir();
    test_forced_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
